// File: rtl/z80_bus_sequencer.sv
// Z80-style bus cycle generator: turns a level request from the CPU core into
// T-state sequenced strobes with programmed and external wait states.
module z80_bus_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int MEM_WAIT    = 0,
  parameter int IO_WAIT     = 1,
  parameter int INTACK_WAIT = 2
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              REQ,
  input  logic              REQ_WR,
  input  logic              REQ_IO,
  input  logic              REQ_M1,
  input  logic              REQ_INTACK,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_DATA,
  output logic              ACK,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              BUSY,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_OE,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              nWAIT,
  output logic              nMREQ,
  output logic              nIORQ,
  output logic              nRD,
  output logic              nWR,
  output logic              nM1
);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;

  state_t            state_q, state_d;
  logic [3:0]        waitCnt_q, waitCnt_d;
  logic              isWr_q, isWr_d;
  logic              isIo_q, isIo_d;
  logic              isMem_q, isMem_d;
  logic              isM1_q, isM1_d;
  logic              isIntack_q, isIntack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dataOut_q, dataOut_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              ack_q, ack_d;
  logic              oe_q, oe_d;
  logic              nMreq_q, nMreq_d;
  logic              nIorq_q, nIorq_d;
  logic              nRd_q, nRd_d;
  logic              nWr_q, nWr_d;
  logic              nM1_q, nM1_d;

  logic              decIntack, decIo, decWr, decMem, decM1;
  logic [3:0]        decWait;
  logic              active, late;

  // INTACK overrides IO and write; M1 only qualifies a plain memory read.
  assign decIntack = REQ_INTACK;
  assign decIo     = !REQ_INTACK && REQ_IO;
  assign decWr     = !REQ_INTACK && REQ_WR;
  assign decMem    = !REQ_INTACK && !REQ_IO;
  assign decM1     = decMem && !decWr && REQ_M1;
  assign decWait   = decIntack ? 4'(INTACK_WAIT) :
                     decIo     ? 4'(IO_WAIT)     : 4'(MEM_WAIT);

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    isWr_d     = isWr_q;
    isIo_d     = isIo_q;
    isMem_d    = isMem_q;
    isM1_d     = isM1_q;
    isIntack_d = isIntack_q;
    addr_d     = addr_q;
    dataOut_d  = dataOut_q;
    rdData_d   = rdData_q;
    ack_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // The ACK cycle is a forced turnaround before the next acceptance.
        if (REQ && !ack_q) begin
          state_d    = T1;
          waitCnt_d  = decWait;
          isWr_d     = decWr;
          isIo_d     = decIo;
          isMem_d    = decMem;
          isM1_d     = decM1;
          isIntack_d = decIntack;
          addr_d     = REQ_ADDR;
          dataOut_d  = REQ_DATA;
        end
      end
      T1: state_d = T2;
      T2: state_d = ((waitCnt_q != 4'd0) || !nWAIT) ? TW : T3;
      TW: begin
        waitCnt_d = (waitCnt_q != 4'd0) ? waitCnt_q - 4'd1 : 4'd0;
        if ((waitCnt_d == 4'd0) && nWAIT) state_d = T3;
      end
      T3: begin
        state_d = IDLE;
        ack_d   = 1'b1;
        if (!isWr_q) rdData_d = DATA_IN;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are derived from the state being entered so they come out registered.
    active  = (state_d != IDLE);
    late    = (state_d == T2) || (state_d == TW) || (state_d == T3);
    nM1_d   = !(active && (isM1_d || isIntack_d));
    nMreq_d = !(active && isMem_d);
    nRd_d   = !(active && !isWr_d && (isMem_d || (late && isIo_d)));
    nIorq_d = !(late && (isIo_d || isIntack_d));
    nWr_d   = !(late && isWr_d);
    oe_d    = active && isWr_d;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'd0;
      isWr_q     <= 1'b0;
      isIo_q     <= 1'b0;
      isMem_q    <= 1'b0;
      isM1_q     <= 1'b0;
      isIntack_q <= 1'b0;
      addr_q     <= '0;
      dataOut_q  <= '0;
      rdData_q   <= '0;
      ack_q      <= 1'b0;
      oe_q       <= 1'b0;
      nMreq_q    <= 1'b1;
      nIorq_q    <= 1'b1;
      nRd_q      <= 1'b1;
      nWr_q      <= 1'b1;
      nM1_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      isWr_q     <= isWr_d;
      isIo_q     <= isIo_d;
      isMem_q    <= isMem_d;
      isM1_q     <= isM1_d;
      isIntack_q <= isIntack_d;
      addr_q     <= addr_d;
      dataOut_q  <= dataOut_d;
      rdData_q   <= rdData_d;
      ack_q      <= ack_d;
      oe_q       <= oe_d;
      nMreq_q    <= nMreq_d;
      nIorq_q    <= nIorq_d;
      nRd_q      <= nRd_d;
      nWr_q      <= nWr_d;
      nM1_q      <= nM1_d;
    end
  end

  assign ACK      = ack_q;
  assign RD_DATA  = rdData_q;
  assign BUSY     = (state_q != IDLE);
  assign ADDRESS  = addr_q;
  assign DATA_OUT = dataOut_q;
  assign DATA_OE  = oe_q;
  assign nMREQ    = nMreq_q;
  assign nIORQ    = nIorq_q;
  assign nRD      = nRd_q;
  assign nWR      = nWr_q;
  assign nM1      = nM1_q;

endmodule

// File: tb/tb_z80_bus_sequencer.sv
// Self-checking bench for z80_bus_sequencer: per-cycle strobe traces plus a
// read-data scoreboard filled at request time and drained against observed ACKs.
module tb_z80_bus_sequencer;

  localparam int TRACE_LEN = 14;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b1;
  logic        REQ = 1'b0;
  logic        REQ_WR = 1'b0;
  logic        REQ_IO = 1'b0;
  logic        REQ_M1 = 1'b0;
  logic        REQ_INTACK = 1'b0;
  logic [15:0] REQ_ADDR = 16'h0;
  logic [7:0]  REQ_DATA = 8'h0;
  logic [7:0]  DATA_IN = 8'h0;
  logic        nWAIT = 1'b1;
  logic        ACK, BUSY, DATA_OE, nMREQ, nIORQ, nRD, nWR, nM1;
  logic [7:0]  RD_DATA, DATA_OUT;
  logic [15:0] ADDRESS;

  int          nTests = 0;
  int          nFail = 0;
  logic [7:0]  expQ[$];
  logic [7:0]  obsQ[$];
  logic [7:0]  lastRd = 8'h00;
  logic [5:0]  trStb[1:TRACE_LEN];
  logic        trAck[1:TRACE_LEN];
  logic        trBusy[1:TRACE_LEN];
  int          ackAt;

  z80_bus_sequencer #(
    .ADDR_W(16), .DATA_W(8), .MEM_WAIT(0), .IO_WAIT(1), .INTACK_WAIT(2)
  ) dut (
    .CLK(CLK), .nRESET(nRESET), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_IO(REQ_IO),
    .REQ_M1(REQ_M1), .REQ_INTACK(REQ_INTACK), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .ACK(ACK), .RD_DATA(RD_DATA), .BUSY(BUSY), .ADDRESS(ADDRESS), .DATA_OUT(DATA_OUT),
    .DATA_OE(DATA_OE), .DATA_IN(DATA_IN), .nWAIT(nWAIT), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .nM1(nM1)
  );

  always #5 CLK = ~CLK;

  // Every completed cycle's read data lands in the observed queue.
  always @(negedge CLK) begin
    if (nRESET && ACK) obsQ.push_back(RD_DATA);
  end

  // Strobe snapshot packed as {DATA_OE, nM1, nMREQ, nIORQ, nRD, nWR}.
  function automatic logic [5:0] stb();
    return {DATA_OE, nM1, nMREQ, nIORQ, nRD, nWR};
  endfunction

  // Issues one request and records TRACE_LEN cycles; cycle 1 is the first after acceptance.
  task automatic applyStimulus(input logic wr, input logic io, input logic m1,
                               input logic intack, input logic [15:0] addr,
                               input logic [7:0] wdata, input logic [7:0] rdata,
                               input int reqHold, input int waitFrom, input int waitLen);
    @(negedge CLK);
    REQ_WR = wr; REQ_IO = io; REQ_M1 = m1; REQ_INTACK = intack;
    REQ_ADDR = addr; REQ_DATA = wdata; DATA_IN = rdata; nWAIT = 1'b1; REQ = 1'b1;
    ackAt = 0;
    for (int c = 1; c <= TRACE_LEN; c++) begin
      @(negedge CLK);
      trStb[c] = stb(); trAck[c] = ACK; trBusy[c] = BUSY;
      if (ACK && ackAt == 0) ackAt = c;
      if (c >= reqHold) REQ = 1'b0;
      nWAIT = !(c >= waitFrom && c < waitFrom + waitLen);
    end
    REQ = 1'b0; nWAIT = 1'b1;
  endtask

  task automatic test_reset();
    #1 nRESET = 1'b0;
    repeat (2) @(negedge CLK);
    nTests++; if (stb() !== 6'b011111) begin nFail++; $display("[TB] FAIL reset_strobes: got %b expected %b", stb(), 6'b011111); end
    nTests++; if (ACK !== 1'b0) begin nFail++; $display("[TB] FAIL reset_ack: got %b expected 0", ACK); end
    nTests++; if (BUSY !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
    nTests++; if (ADDRESS !== 16'h0) begin nFail++; $display("[TB] FAIL reset_address: got %h expected 0000", ADDRESS); end
    nTests++; if (DATA_OUT !== 8'h0) begin nFail++; $display("[TB] FAIL reset_data_out: got %h expected 00", DATA_OUT); end
    nTests++; if (RD_DATA !== 8'h0) begin nFail++; $display("[TB] FAIL reset_rd_data: got %h expected 00", RD_DATA); end
    nRESET = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_mem_read();
    expQ.push_back(8'hA5); lastRd = 8'hA5;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1, 99, 0);
    for (int c = 1; c <= 3; c++) begin
      nTests++; if (trStb[c] !== 6'b010101) begin nFail++; $display("[TB] FAIL mem_read_strobes cycle %0d: got %b expected %b", c, trStb[c], 6'b010101); end
    end
    nTests++; if (ackAt !== 4) begin nFail++; $display("[TB] FAIL mem_read_ack_cycle: got %0d expected 4", ackAt); end
    nTests++; if (trStb[4] !== 6'b011111) begin nFail++; $display("[TB] FAIL mem_read_release: got %b expected %b", trStb[4], 6'b011111); end
    nTests++; if (trAck[5] !== 1'b0) begin nFail++; $display("[TB] FAIL mem_read_ack_width: got %b expected 0", trAck[5]); end
    nTests++; if (trBusy[2] !== 1'b1 || trBusy[4] !== 1'b0) begin nFail++; $display("[TB] FAIL mem_read_busy: got %b%b expected 10", trBusy[2], trBusy[4]); end
    nTests++; if (ADDRESS !== 16'h1234) begin nFail++; $display("[TB] FAIL mem_read_address: got %h expected 1234", ADDRESS); end
  endtask

  task automatic test_m1_fetch();
    expQ.push_back(8'hD7); lastRd = 8'hD7;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0038, 8'h00, 8'hD7, 1, 99, 0);
    for (int c = 1; c <= 3; c++) begin
      nTests++; if (trStb[c] !== 6'b000101) begin nFail++; $display("[TB] FAIL m1_fetch_strobes cycle %0d: got %b expected %b", c, trStb[c], 6'b000101); end
    end
    nTests++; if (ackAt !== 4) begin nFail++; $display("[TB] FAIL m1_fetch_ack_cycle: got %0d expected 4", ackAt); end
    // M1 on a write is ignored, and writes leave the captured read data alone.
    expQ.push_back(lastRd);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0038, 8'h55, 8'h66, 1, 99, 0);
    nTests++; if (trStb[1] !== 6'b110111) begin nFail++; $display("[TB] FAIL m1_write_t1: got %b expected %b", trStb[1], 6'b110111); end
    for (int c = 2; c <= 3; c++) begin
      nTests++; if (trStb[c] !== 6'b110110) begin nFail++; $display("[TB] FAIL m1_write_strobes cycle %0d: got %b expected %b", c, trStb[c], 6'b110110); end
    end
    nTests++; if (ackAt !== 4) begin nFail++; $display("[TB] FAIL m1_write_ack_cycle: got %0d expected 4", ackAt); end
  endtask

  task automatic test_io_write();
    expQ.push_back(lastRd);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h00FE, 8'h3C, 8'h99, 1, 99, 0);
    nTests++; if (trStb[1] !== 6'b111111) begin nFail++; $display("[TB] FAIL io_write_t1: got %b expected %b", trStb[1], 6'b111111); end
    for (int c = 2; c <= 4; c++) begin
      nTests++; if (trStb[c] !== 6'b111010) begin nFail++; $display("[TB] FAIL io_write_strobes cycle %0d: got %b expected %b", c, trStb[c], 6'b111010); end
    end
    nTests++; if (ackAt !== 5) begin nFail++; $display("[TB] FAIL io_write_ack_cycle: got %0d expected 5", ackAt); end
    nTests++; if (trStb[5] !== 6'b011111) begin nFail++; $display("[TB] FAIL io_write_release: got %b expected %b", trStb[5], 6'b011111); end
    nTests++; if (DATA_OUT !== 8'h3C) begin nFail++; $display("[TB] FAIL io_write_data_out: got %h expected 3c", DATA_OUT); end
    nTests++; if (ADDRESS !== 16'h00FE) begin nFail++; $display("[TB] FAIL io_write_address: got %h expected 00fe", ADDRESS); end
  endtask

  task automatic test_intack();
    expQ.push_back(8'hFF); lastRd = 8'hFF;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h12, 8'hFF, 1, 99, 0);
    nTests++; if (trStb[1] !== 6'b001111) begin nFail++; $display("[TB] FAIL intack_t1: got %b expected %b", trStb[1], 6'b001111); end
    for (int c = 2; c <= 5; c++) begin
      nTests++; if (trStb[c] !== 6'b001011) begin nFail++; $display("[TB] FAIL intack_strobes cycle %0d: got %b expected %b", c, trStb[c], 6'b001011); end
    end
    nTests++; if (ackAt !== 6) begin nFail++; $display("[TB] FAIL intack_ack_cycle: got %0d expected 6", ackAt); end
    nTests++; if (RD_DATA !== 8'hFF) begin nFail++; $display("[TB] FAIL intack_vector: got %h expected ff", RD_DATA); end
  endtask

  task automatic test_ext_wait();
    expQ.push_back(8'h5A); expQ.push_back(8'h5A); lastRd = 8'h5A;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, 8'h00, 8'h5A, 9, 2, 3);
    for (int c = 1; c <= 6; c++) begin
      nTests++; if (trStb[c] !== 6'b010101) begin nFail++; $display("[TB] FAIL ext_wait_strobes cycle %0d: got %b expected %b", c, trStb[c], 6'b010101); end
    end
    nTests++; if (ackAt !== 7) begin nFail++; $display("[TB] FAIL ext_wait_ack_cycle: got %0d expected 7", ackAt); end
    nTests++; if (trStb[8] !== 6'b011111 || trAck[8] !== 1'b0) begin nFail++; $display("[TB] FAIL ext_wait_turnaround: got %b/%b expected 011111/0", trStb[8], trAck[8]); end
    nTests++; if (trStb[9] !== 6'b010101) begin nFail++; $display("[TB] FAIL ext_wait_next_t1: got %b expected %b", trStb[9], 6'b010101); end
    nTests++; if (trAck[12] !== 1'b1) begin nFail++; $display("[TB] FAIL ext_wait_second_ack: got %b expected 1", trAck[12]); end
  endtask

  task automatic test_back_to_back();
    expQ.push_back(8'h11); expQ.push_back(8'h11); lastRd = 8'h11;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'h11, 6, 99, 0);
    nTests++; if (trAck[4] !== 1'b1 || trAck[9] !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_acks: got %b%b expected 11", trAck[4], trAck[9]); end
    nTests++; if (trStb[5] !== 6'b011111) begin nFail++; $display("[TB] FAIL b2b_gap: got %b expected %b", trStb[5], 6'b011111); end
    nTests++; if (trStb[6] !== 6'b010101) begin nFail++; $display("[TB] FAIL b2b_second_t1: got %b expected %b", trStb[6], 6'b010101); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    REQ_WR = 1'b0; REQ_IO = 1'b1; REQ_M1 = 1'b0; REQ_INTACK = 1'b0;
    REQ_ADDR = 16'h0010; DATA_IN = 8'h77; REQ = 1'b1;
    repeat (3) @(negedge CLK);
    REQ = 1'b0;
    nTests++; if (stb() !== 6'b011001) begin nFail++; $display("[TB] FAIL reset_mid_in_tw: got %b expected %b", stb(), 6'b011001); end
    nRESET = 1'b0;
    #1;
    nTests++; if (stb() !== 6'b011111) begin nFail++; $display("[TB] FAIL reset_mid_strobes: got %b expected %b", stb(), 6'b011111); end
    nTests++; if (BUSY !== 1'b0 || ACK !== 1'b0) begin nFail++; $display("[TB] FAIL reset_mid_busy_ack: got %b%b expected 00", BUSY, ACK); end
    @(negedge CLK);
    nTests++; if (ACK !== 1'b0 || RD_DATA !== 8'h00) begin nFail++; $display("[TB] FAIL reset_mid_hold: got ack %b rd %h expected 0 00", ACK, RD_DATA); end
    nRESET = 1'b1; lastRd = 8'h00;
    @(negedge CLK);
    expQ.push_back(8'h3E); lastRd = 8'h3E;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 8'h3E, 1, 99, 0);
    nTests++; if (trStb[1] !== 6'b010101) begin nFail++; $display("[TB] FAIL reset_mid_new_read: got %b expected %b", trStb[1], 6'b010101); end
    nTests++; if (ackAt !== 4) begin nFail++; $display("[TB] FAIL reset_mid_new_ack: got %0d expected 4", ackAt); end
  endtask

  task automatic test_scoreboard();
    nTests++; if (obsQ.size() !== expQ.size()) begin nFail++; $display("[TB] FAIL scoreboard_count: got %0d expected %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      logic [7:0] e, o;
      e = expQ.pop_front(); o = obsQ.pop_front();
      nTests++; if (o !== e) begin nFail++; $display("[TB] FAIL scoreboard_rd_data: got %h expected %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_m1_fetch();
    test_io_write();
    test_intack();
    test_ext_wait();
    test_back_to_back();
    test_reset_mid();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
